// File: rtl/gol_pkg.sv
// Shared game-of-life definitions: default grid size, cell indexing,
// population width and the frame reader state encoding.
package gol_pkg;

  localparam int DEFAULT_SIZE = 8;
  localparam int POP_W        = $clog2(DEFAULT_SIZE * DEFAULT_SIZE + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Bits needed to count every live cell of a size x size board.
  function automatic int pop_width(input int size);
    return $clog2(size * size + 1);
  endfunction

  // Flattened index of cell (x,y); coordinates wrap around the torus.
  function automatic int cell_index(input int x, input int y, input int size);
    int xw;
    int yw;
    xw = ((x % size) + size) % size;
    yw = ((y % size) + size) % size;
    return xw + yw * size;
  endfunction

endpackage

// File: rtl/gol_frame_reader_if.sv
// Board capture input and row stream output of the frame reader.
// master = frame reader, slave = grid/downstream side.
interface gol_frame_reader_if
  import gol_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int GEN_W  = 16,
  parameter int DROP_W = 8
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW    = pop_width(SIZE);

  logic [SIZE*SIZE-1:0] i_board;
  logic                 i_board_valid;
  logic                 i_ready;
  logic                 o_valid;
  logic [SIZE-1:0]      o_row;
  logic [IDX_W-1:0]     o_row_idx;
  logic                 o_sof;
  logic                 o_eof;
  logic [GEN_W-1:0]     o_gen;
  logic [PW-1:0]        o_pop;
  logic                 o_stable;
  logic                 o_empty;
  logic                 o_frame_done;
  logic [DROP_W-1:0]    o_drop_cnt;

  modport master (
    input  i_board, i_board_valid, i_ready,
    output o_valid, o_row, o_row_idx, o_sof, o_eof, o_gen, o_pop,
           o_stable, o_empty, o_frame_done, o_drop_cnt
  );

  modport slave (
    output i_board, i_board_valid, i_ready,
    input  o_valid, o_row, o_row_idx, o_sof, o_eof, o_gen, o_pop,
           o_stable, o_empty, o_frame_done, o_drop_cnt
  );
endinterface

// File: rtl/gol_row_popcount.sv
// Combinational count of live cells in one board row.
module gol_row_popcount #(
  parameter int SIZE  = 8,
  parameter int CNT_W = $clog2(SIZE + 1)
) (
  input  logic [SIZE-1:0]  row,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < SIZE; i++) begin
      count = count + CNT_W'(row[i]);
    end
  end

endmodule

// File: rtl/gol_frame_reader.sv
// Captures a board snapshot per generation strobe and streams it out one row
// per valid/ready beat, tracking generation, population and drop metadata.
module gol_frame_reader
  import gol_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int GEN_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  gol_frame_reader_if.master bus
);

  localparam int IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W  = pop_width(SIZE);
  localparam int RCNT_W = $clog2(SIZE + 1);

  state_t               state_reg, state_next;
  logic [SIZE*SIZE-1:0] snap_reg;
  logic [SIZE*SIZE-1:0] prev_reg;
  logic                 prev_valid_reg;
  logic [GEN_W-1:0]     gen_reg;
  logic [IDX_W-1:0]     row_idx_reg;
  logic [CNT_W-1:0]     acc_reg;
  logic [CNT_W-1:0]     pop_reg;
  logic                 empty_reg;
  logic                 stable_reg;
  logic                 frame_done_reg;
  logic [DROP_W-1:0]    drop_reg;

  logic [SIZE-1:0]   rows [SIZE];
  logic [SIZE-1:0]   row_cur;
  logic [RCNT_W-1:0] row_pop;
  logic [CNT_W-1:0]  acc_sum;
  logic              sending;
  logic              accept_last;
  logic              load;
  logic              drop;

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_rows
      assign rows[gi] = snap_reg[cell_index(0, gi, SIZE) +: SIZE];
    end
  endgenerate

  assign row_cur = rows[row_idx_reg];

  gol_row_popcount #(.SIZE(SIZE), .CNT_W(RCNT_W)) u_popcount (
    .row   (row_cur),
    .count (row_pop)
  );

  assign sending     = (state_reg == ST_SEND);
  assign acc_sum     = acc_reg + CNT_W'(row_pop);
  assign accept_last = sending && bus.i_ready && (row_idx_reg == IDX_W'(SIZE - 1));
  // A strobe landing on the final accept starts the next frame with no bubble.
  assign load        = bus.i_board_valid && (!sending || accept_last);
  assign drop        = bus.i_board_valid && sending && !accept_last;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (load) state_next = ST_SEND;
      ST_SEND: if (accept_last) state_next = load ? ST_SEND : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= ST_IDLE;
      snap_reg       <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      gen_reg        <= '0;
      row_idx_reg    <= '0;
      acc_reg        <= '0;
      pop_reg        <= '0;
      empty_reg      <= 1'b0;
      stable_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      drop_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= accept_last;
      if (sending && bus.i_ready) begin
        acc_reg     <= acc_sum;
        row_idx_reg <= accept_last ? '0 : row_idx_reg + IDX_W'(1);
      end
      if (accept_last) begin
        pop_reg   <= acc_sum;
        empty_reg <= (acc_sum == '0);
      end
      // Placed after the row update so a new frame restarts the row counter.
      if (load) begin
        snap_reg       <= bus.i_board;
        stable_reg     <= prev_valid_reg && (bus.i_board == prev_reg);
        prev_reg       <= bus.i_board;
        prev_valid_reg <= 1'b1;
        gen_reg        <= gen_reg + GEN_W'(1);
        acc_reg        <= '0;
        row_idx_reg    <= '0;
      end
      if (drop && (drop_reg != {DROP_W{1'b1}})) begin
        drop_reg <= drop_reg + DROP_W'(1);
      end
    end
  end

  assign bus.o_valid      = sending;
  assign bus.o_row        = sending ? row_cur : '0;
  assign bus.o_row_idx    = row_idx_reg;
  assign bus.o_sof        = sending && (row_idx_reg == '0);
  assign bus.o_eof        = sending && (row_idx_reg == IDX_W'(SIZE - 1));
  assign bus.o_gen        = gen_reg;
  assign bus.o_pop        = pop_reg;
  assign bus.o_stable     = stable_reg;
  assign bus.o_empty      = empty_reg;
  assign bus.o_frame_done = frame_done_reg;
  assign bus.o_drop_cnt   = drop_reg;

endmodule
